// File: rtl/fb_pkg.sv
// Shared types and default widths for the framebuffer VRAM arbiter.
package fb_pkg;

  localparam int FB_ADDR_W      = 15;
  localparam int FB_DATA_W      = 8;
  localparam int FB_QUEUE_DEPTH = 4;
  localparam int FB_CLEAR_LAST  = 32767;

  // One buffered CPU write: VRAM address plus pixel value.
  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_wr_t;

  // Background clear engine states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  // Build a queue entry from a captured bus sample.
  function automatic fb_wr_t fb_pack_wr(input logic [FB_ADDR_W-1:0] addr,
                                        input logic [FB_DATA_W-1:0] data);
    fb_wr_t wr;
    wr.addr = addr;
    wr.data = data;
    return wr;
  endfunction

endpackage

// File: rtl/fb_vram_arbiter_if.sv
// Bus bundle between the framebuffer arbiter and its surroundings:
// 6502 capture inputs, scanout fetch, clear control, VRAM port and status.
interface fb_vram_arbiter_if
  import fb_pkg::*;
#(
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = FB_DATA_W,
  parameter int QUEUE_DEPTH = FB_QUEUE_DEPTH
);

  localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;

  // 6502 bus (asynchronous to the pixel clock)
  logic              Phi2;
  logic              RW_n;
  logic              AddrSel;
  logic [ADDR_W-1:0] AddrPhys;
  logic [DATA_W-1:0] DataIn;

  // Scanout fetch
  logic              ScanReq;
  logic [ADDR_W-1:0] ScanAddr;
  logic              ScanValid;
  logic [DATA_W-1:0] ScanData;

  // Clear engine
  logic              ClearReq;
  logic [DATA_W-1:0] ClearColor;
  logic              ClearBusy;

  // VRAM macro port
  logic [ADDR_W-1:0] VramAddr;
  logic [DATA_W-1:0] VramWData;
  logic              VramWe;
  logic [DATA_W-1:0] VramRData;

  // Status
  logic [LVL_W-1:0]  QueueLevel;
  logic              Overflow;

  // Arbiter side
  modport slave (
    input  Phi2, RW_n, AddrSel, AddrPhys, DataIn,
    input  ScanReq, ScanAddr, ClearReq, ClearColor, VramRData,
    output ScanValid, ScanData, ClearBusy,
    output VramAddr, VramWData, VramWe, QueueLevel, Overflow
  );

  // Environment side (bus, scanout, VRAM model)
  modport master (
    output Phi2, RW_n, AddrSel, AddrPhys, DataIn,
    output ScanReq, ScanAddr, ClearReq, ClearColor, VramRData,
    input  ScanValid, ScanData, ClearBusy,
    input  VramAddr, VramWData, VramWe, QueueLevel, Overflow
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO of CPU writes. A push while full is accepted only
// when a pop frees a slot in the same cycle; a pop while empty is ignored.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter  int DEPTH = FB_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  fb_wr_t           wdata_i,
  input  logic             pop_i,
  output fb_wr_t           rdata_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  fb_wr_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == {LVL_W{1'b0}});
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Qualify push/pop against the current occupancy.
  always_comb begin
    pop_ok_s  = pop_i && !empty_o;
    push_ok_s = push_i && (!full_o || pop_ok_s);
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/fb_vram_arbiter.sv
// Framebuffer VRAM arbiter: shares the single-port VRAM between scanout
// fetches (always served immediately), buffered 6502 writes captured from
// the Phi2 bus, and a background fill engine, in that priority order.
module fb_vram_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = FB_DATA_W,
  parameter int QUEUE_DEPTH = FB_QUEUE_DEPTH,
  parameter int CLEAR_LAST  = FB_CLEAR_LAST
) (
  input logic                Clk,
  input logic                Reset_n,
  fb_vram_arbiter_if.slave   bus
);

  localparam int                LVL_W        = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] CLEAR_LAST_A = ADDR_W'(CLEAR_LAST);

  // ---------------- Phi2 capture ----------------
  logic              phi2_meta_q;
  logic              phi2_sync_q;
  logic              phi2_prev_q;
  logic              smp_rw_n_q;
  logic              smp_sel_q;
  logic [ADDR_W-1:0] smp_addr_q;
  logic [DATA_W-1:0] smp_data_q;
  logic              phi2_fall_s;

  // Two-flop synchronizer for Phi2 plus one delay stage for edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      phi2_meta_q <= 1'b0;
      phi2_sync_q <= 1'b0;
      phi2_prev_q <= 1'b0;
    end else begin
      phi2_meta_q <= bus.Phi2;
      phi2_sync_q <= phi2_meta_q;
      phi2_prev_q <= phi2_sync_q;
    end
  end

  // Keep re-sampling the CPU bus while Phi2 is high; the last sample wins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      smp_rw_n_q <= 1'b0;
      smp_sel_q  <= 1'b0;
      smp_addr_q <= {ADDR_W{1'b0}};
      smp_data_q <= {DATA_W{1'b0}};
    end else if (phi2_sync_q) begin
      smp_rw_n_q <= bus.RW_n;
      smp_sel_q  <= bus.AddrSel;
      smp_addr_q <= bus.AddrPhys;
      smp_data_q <= bus.DataIn;
    end
  end

  // ---------------- CPU write queue ----------------
  logic             push_s;
  logic             pop_s;
  fb_wr_t           push_wr_s;
  fb_wr_t           head_wr_s;
  logic [LVL_W-1:0] q_level_s;
  logic             q_full_s;
  logic             q_empty_s;
  logic             overflow_q;

  // Push framebuffer writes on the synchronized Phi2 falling edge; pop
  // whenever the VRAM is not claimed by scanout.
  always_comb begin
    phi2_fall_s = phi2_prev_q && !phi2_sync_q;
    push_s      = phi2_fall_s && !smp_rw_n_q && smp_sel_q;
    pop_s       = !bus.ScanReq && !q_empty_s;
    push_wr_s   = fb_pack_wr(smp_addr_q, smp_data_q);
  end

  fb_wr_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_wr_fifo (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .push_i  (push_s),
    .wdata_i (push_wr_s),
    .pop_i   (pop_s),
    .rdata_o (head_wr_s),
    .level_o (q_level_s),
    .full_o  (q_full_s),
    .empty_o (q_empty_s)
  );

  // Sticky drop flag: a push found the queue full with no pop to make room.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      overflow_q <= 1'b0;
    end else if (push_s && q_full_s && !pop_s) begin
      overflow_q <= 1'b1;
    end
  end

  // ---------------- Clear engine ----------------
  clr_state_t        state_q;
  clr_state_t        state_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] clr_cnt_d;
  logic [DATA_W-1:0] clr_color_q;
  logic [DATA_W-1:0] clr_color_d;
  logic              clr_issue_s;
  logic              clear_busy_q;

  // Next-state logic: a request always restarts the fill; otherwise the
  // counter advances only on cycles left over by scanout and CPU writes.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    clr_issue_s = (state_q == CLEAR) && !bus.ScanReq && q_empty_s && !bus.ClearReq;
    if (bus.ClearReq) begin
      state_d     = CLEAR;
      clr_cnt_d   = {ADDR_W{1'b0}};
      clr_color_d = bus.ClearColor;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        CLEAR: begin
          if (clr_issue_s) begin
            if (clr_cnt_q == CLEAR_LAST_A) begin
              state_d = DONE;
            end else begin
              clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
          end else begin
            state_d = CLEAR;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Clear engine state, counter, latched colour and registered busy flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      clr_cnt_q    <= {ADDR_W{1'b0}};
      clr_color_q  <= {DATA_W{1'b0}};
      clear_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_color_q  <= clr_color_d;
      clear_busy_q <= (state_d == CLEAR);
    end
  end

  // ---------------- VRAM port ----------------
  logic [ADDR_W-1:0] vram_addr_q;
  logic [DATA_W-1:0] vram_wdata_q;
  logic              vram_we_q;
  logic              scan_pend_q;
  logic              scan_valid_q;

  // Fixed-priority grant: scanout, then queued CPU write, then clear fill.
  // On idle cycles the address is held and the write enable dropped.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vram_addr_q  <= {ADDR_W{1'b0}};
      vram_wdata_q <= {DATA_W{1'b0}};
      vram_we_q    <= 1'b0;
    end else if (bus.ScanReq) begin
      vram_addr_q <= bus.ScanAddr;
      vram_we_q   <= 1'b0;
    end else if (pop_s) begin
      vram_addr_q  <= head_wr_s.addr;
      vram_wdata_q <= head_wr_s.data;
      vram_we_q    <= 1'b1;
    end else if (clr_issue_s) begin
      vram_addr_q  <= clr_cnt_q;
      vram_wdata_q <= clr_color_q;
      vram_we_q    <= 1'b1;
    end else begin
      vram_we_q <= 1'b0;
    end
  end

  // Track scan reads through the address register and the VRAM read stage.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      scan_pend_q  <= 1'b0;
      scan_valid_q <= 1'b0;
    end else begin
      scan_pend_q  <= bus.ScanReq;
      scan_valid_q <= scan_pend_q;
    end
  end

  assign bus.VramAddr   = vram_addr_q;
  assign bus.VramWData  = vram_wdata_q;
  assign bus.VramWe     = vram_we_q;
  assign bus.ScanValid  = scan_valid_q;
  // VRAM read data arrives in the cycle ScanValid is high; gate it otherwise.
  assign bus.ScanData   = scan_valid_q ? bus.VramRData : {DATA_W{1'b0}};
  assign bus.ClearBusy  = clear_busy_q;
  assign bus.QueueLevel = q_level_s;
  assign bus.Overflow   = overflow_q;

endmodule

// File: doc/fb_vram_arbiter.md
Name: fb_vram_arbiter

Overview:
- Shares the framebuffer's single-port VRAM between two requesters: the scanout pixel fetcher, which has hard real-time priority, and 6502 bus writes captured from the Phi2 bus.
- Also runs a background clear engine that fills VRAM with one colour.
- Sits between the CPU bus interface and the VRAM macro inside Fb, in the pixel clock domain.
- Buffers CPU writes in a small queue so scanout fetches never stall.

Parameters:
ADDR_W, 15, VRAM address width (matches AddrPhys[14:0]; AddrSel = AddrPhys[15])
DATA_W, 8, pixel width (RGB 3-3-2)
QUEUE_DEPTH, 4, CPU write queue entries (power of two, >= 2)
CLEAR_LAST, 32767, last address written by the clear engine

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  asynchronous active-low reset
Phi2  in  1  6502 phase-2 clock, asynchronous to Clk
RW_n  in  1  6502 read/write (0 = write)
AddrSel  in  1  framebuffer select (AddrPhys[15])
AddrPhys  in  ADDR_W  CPU address bits [14:0]
DataIn  in  DATA_W  CPU write data
ScanReq  in  1  scanout fetch request, one per pixel fetch
ScanAddr  in  ADDR_W  scanout fetch address
ScanValid  out  1  ScanData valid
ScanData  out  DATA_W  fetched pixel
ClearReq  in  1  single-cycle pulse: start fill
ClearColor  in  DATA_W  fill value, sampled with ClearReq
ClearBusy  out  1  fill in progress
VramAddr  out  ADDR_W  VRAM address (registered)
VramWData  out  DATA_W  VRAM write data (registered)
VramWe  out  1  VRAM write enable (registered)
VramRData  in  DATA_W  VRAM read data, valid one cycle after the read address
QueueLevel  out  $clog2(QUEUE_DEPTH)+1  occupied queue entries
Overflow  out  1  sticky: a CPU write was dropped

Behaviour:
- Reset values: all outputs 0, queue empty, FSM in IDLE, synchronizers cleared.
- Bus capture:
  - Phi2 passes through a 2-flop synchronizer.
  - On every Clk where the synchronized Phi2 is 1, register {RW_n, AddrSel, AddrPhys, DataIn}.
  - On the synchronized falling edge, push the last registered sample if RW_n=0 and AddrSel=1.
  - Requires Clk >= 4x Phi2 frequency.
- Queue full at push time: the write is dropped, Overflow is set, and it stays set until reset. A pop in the same cycle frees one slot, so the push is accepted and Overflow stays clear.
- Arbitration per cycle, in priority order: ScanReq > queued CPU write > clear engine > idle. The winner is driven on the Vram* registers in the next cycle.
- Scan read: ScanReq at cycle N -> VramAddr=ScanAddr, VramWe=0 at N+1 -> ScanValid=1, ScanData=VramRData at N+2. Back-to-back ScanReq gives one result per cycle. No request is ever delayed.
- CPU write: popped in cycle N when ScanReq=0 and queue non-empty -> VramWe=1 with that address/data at N+1. Queue order is preserved.
- Clear FSM states:
  - IDLE: ClearReq -> CLEAR. Counter=0, colour latched, ClearBusy=1 from the next cycle.
  - CLEAR: the counter writes only in cycles not used by scan or CPU. It increments after each issued write. After issuing CLEAR_LAST -> DONE.
  - DONE: one cycle, ClearBusy drops -> IDLE.
  - ClearReq during CLEAR or DONE restarts from address 0 with the new colour.
- CPU writes are not protected against a later clear pass; software waits for ClearBusy=0.
- Idle cycles: VramWe=0, VramAddr holds its previous value.
- Reset mid-operation: the queue is discarded and the clear is aborted. The Vram* outputs go to 0 asynchronously.

Decomposition:
- Package fb_pkg:
  - typedef fb_wr_t packed struct {addr, data}
  - enum clr_state_t {IDLE, CLEAR, DONE}
  - localparams for the default widths
- Sub-module fb_wr_fifo: synchronous FIFO of fb_wr_t with push/pop/level/full/empty. Push is accepted when full only if a pop occurs in the same cycle.
- Arbiter, synchronizer and clear FSM live in fb_vram_arbiter.

Test Plan:
- Single CPU write (Phi2 20x slower than Clk, AddrPhys=0x8123, DataIn=0xA5, RW_n=0), ScanReq=0 -> exactly one VramWe pulse with VramAddr=0x0123, VramWData=0xA5, 3-5 Clk after Phi2 falls. A read cycle (RW_n=1) or AddrSel=0 -> no write.
- ScanReq held high for 40 cycles with a VRAM model; a CPU write arrives mid-burst -> ScanValid every cycle with latency 2 and correct data. The write is issued on the first cycle after ScanReq drops.
- 5 CPU writes with ScanReq=1 continuously (QUEUE_DEPTH=4) -> 4th entry fills the queue, 5th dropped, Overflow=1, QueueLevel=4. After ScanReq drops, 4 writes come out in order.
- ClearReq with ClearColor=0xE0, CLEAR_LAST=63, no other traffic -> 64 consecutive writes to 0..63 with 0xE0, then ClearBusy falls.
- Clear interleaved with alternating ScanReq and one CPU write -> scan results unaffected. The CPU write precedes pending clear writes. Every address 0..63 is written exactly once by the clear.
- Reset_n asserted mid-clear with 2 writes queued -> outputs 0 immediately. After release: QueueLevel=0, ClearBusy=0, no further VRAM writes.
